fast_frame_ctrl: RTL and testbench

FAST_FRAME_CTRL -- requirements
Module: fast_frame_ctrl

---
 rtl/fast_frame_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fast_frame_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_frame_ctrl.sv
// Frame controller in front of a FAST corner / NMS pipeline.
// Aligns to start-of-frame, tags each accepted pixel with its (x, y) coordinate,
// gates the pipeline clock enable, then drains the pipeline after the last pixel.
module fast_frame_ctrl #(
    parameter int unsigned COL_NUM    = 640,
    parameter int unsigned ROW_NUM    = 480,
    parameter int unsigned FAST_DELAY = 12,
    parameter int unsigned NMS_SIZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pix_in,
    input  logic       pix_vld,
    input  logic       pix_sof,
    output logic       pix_rdy,
    input  logic       dn_rdy,
    output logic       ce,
    output logic [7:0] pix_out,
    output logic [9:0] x_coord,
    output logic [9:0] y_coord,
    output logic       xy_coord_vld,
    output logic       score_eol,
    output logic       busy,
    output logic       frame_done,
    output logic       err_sof
);

    // Pipeline cycles needed to push the last pixel's score out of the NMS window.
    localparam int unsigned FLUSH_LEN = (NMS_SIZE - 1) * COL_NUM + FAST_DELAY;
    localparam int unsigned FlushCntW = (FLUSH_LEN < 1) ? 1 : $clog2(FLUSH_LEN + 1);

    localparam logic [9:0]           XLast     = 10'(COL_NUM - 1);
    localparam logic [9:0]           YLast     = 10'(ROW_NUM - 1);
    localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FLUSH_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSof,
        StActive,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Coordinate of the next expected pixel
    logic [9:0]           x_q, x_d;
    logic [9:0]           y_q, y_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;

    // Registered outputs
    logic       ce_q, ce_d;
    logic [7:0] pix_q, pix_d;
    logic [9:0] xc_q, xc_d;
    logic [9:0] yc_q, yc_d;
    logic       xyv_q, xyv_d;
    logic       eol_q, eol_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       accepting;
    logic       beat;
    logic       take;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic       last_pix;
    logic       flush_end;

    // Handshake and per-beat decode
    always_comb begin
        accepting = (state_q == StWaitSof) || (state_q == StActive);
        pix_rdy   = accepting & dn_rdy;
        beat      = pix_vld & pix_rdy;
        // Before SOF only a framed beat is kept; junk is consumed and dropped.
        take      = beat & ((state_q == StActive) | pix_sof);
        // Any SOF beat is pixel (0,0), which also resynchronises a broken frame.
        cur_x     = pix_sof ? 10'd0 : x_q;
        cur_y     = pix_sof ? 10'd0 : y_q;
        last_pix  = take && (cur_x == XLast) && (cur_y == YLast);
        flush_end = (state_q == StFlush) && dn_rdy && (flush_cnt_q == FlushLast);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StWaitSof;
            StWaitSof: if (take) state_d = last_pix ? StFlush : StActive;
            StActive:  if (last_pix) state_d = StFlush;
            StFlush:   if (flush_end) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output and counter next values; everything not touched holds
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        flush_cnt_d = flush_cnt_q;
        ce_d        = 1'b0;
        pix_d       = pix_q;
        xc_d        = xc_q;
        yc_d        = yc_q;
        xyv_d       = xyv_q;
        eol_d       = eol_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (take) begin
            ce_d  = 1'b1;
            pix_d = pix_in;
            xc_d  = cur_x;
            yc_d  = cur_y;
            xyv_d = 1'b1;
            eol_d = (cur_x == XLast);
            if (cur_x == XLast) begin
                x_d = 10'd0;
                y_d = (cur_y == YLast) ? 10'd0 : cur_y + 10'd1;
            end else begin
                x_d = cur_x + 10'd1;
                y_d = cur_y;
            end
            if ((state_q == StActive) && pix_sof && ((x_q != 10'd0) || (y_q != 10'd0))) begin
                err_d = 1'b1;
            end
            if (last_pix) begin
                flush_cnt_d = '0;
            end
        end

        if (state_q == StFlush) begin
            ce_d  = dn_rdy;
            pix_d = 8'd0;
            xyv_d = 1'b0;
            eol_d = 1'b0;
            if (dn_rdy) begin
                flush_cnt_d = flush_cnt_q + FlushCntW'(1);
            end
        end

        if (state_q == StDone) begin
            done_d = 1'b1;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            flush_cnt_q <= '0;
            ce_q        <= 1'b0;
            pix_q       <= '0;
            xc_q        <= '0;
            yc_q        <= '0;
            xyv_q       <= 1'b0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            flush_cnt_q <= flush_cnt_d;
            ce_q        <= ce_d;
            pix_q       <= pix_d;
            xc_q        <= xc_d;
            yc_q        <= yc_d;
            xyv_q       <= xyv_d;
            eol_q       <= eol_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ce           = ce_q;
    assign pix_out      = pix_q;
    assign x_coord      = xc_q;
    assign y_coord      = yc_q;
    assign xy_coord_vld = xyv_q;
    assign score_eol    = eol_q;
    assign busy         = (state_q != StIdle);
    assign frame_done   = done_q;
    assign err_sof      = err_q;

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// Bench for fast_frame_ctrl on a 4x3 frame (flush length 10).
module tb_fast_frame_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int NPIX = COLS * ROWS;
    localparam int FLEN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_vld = 1'b0;
    logic       pix_sof = 1'b0;
    logic       dn_rdy = 1'b0;
    logic       pix_rdy;
    logic       ce;
    logic [7:0] pix_out;
    logic [9:0] x_coord;
    logic [9:0] y_coord;
    logic       xy_coord_vld;
    logic       score_eol;
    logic       busy;
    logic       frame_done;
    logic       err_sof;

    always #5 clk = ~clk;

    fast_frame_ctrl #(
        .COL_NUM   (COLS),
        .ROW_NUM   (ROWS),
        .FAST_DELAY(2),
        .NMS_SIZE  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pix_in      (pix_in),
        .pix_vld     (pix_vld),
        .pix_sof     (pix_sof),
        .pix_rdy     (pix_rdy),
        .dn_rdy      (dn_rdy),
        .ce          (ce),
        .pix_out     (pix_out),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .xy_coord_vld(xy_coord_vld),
        .score_eol   (score_eol),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_sof     (err_sof)
    );

    int    checks = 0;
    int    failures = 0;
    string scen = "init";

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h", scen, name, got, exp);
        end
    endtask

    // {ce, pix_out, x, y, xy_vld, eol, busy, frame_done, err_sof}
    function automatic logic [33:0] mk(input logic c, input logic [7:0] p, input logic [9:0] x,
                                       input logic [9:0] y, input logic v, input logic e,
                                       input logic b, input logic d, input logic er);
        return {c, p, x, y, v, e, b, d, er};
    endfunction

    function automatic logic [33:0] outs();
        return {ce, pix_out, x_coord, y_coord, xy_coord_vld, score_eol, busy, frame_done,
                err_sof};
    endfunction

    // One clock: apply inputs, sample pix_rdy before the edge, outputs 1 time unit after it.
    task automatic drive(input logic st, input logic v, input logic s, input logic dr,
                         input logic r, input logic [7:0] d, output logic rdy_seen);
        start   = st;
        pix_vld = v;
        pix_sof = s;
        dn_rdy  = dr;
        rst     = r;
        pix_in  = d;
        #1;
        rdy_seen = pix_rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven nominal frame ----------------
    typedef struct {
        logic        st;
        logic        v;
        logic        s;
        logic        dr;
        logic [7:0]  d;
        logic        e_rdy;
        logic [33:0] e_out;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mkvec(input logic st, input logic v, input logic s, input logic dr,
                                   input logic [7:0] d, input logic e_rdy,
                                   input logic [33:0] e_out);
        vec_t t;
        t.st = st; t.v = v; t.s = s; t.dr = dr; t.d = d; t.e_rdy = e_rdy; t.e_out = e_out;
        return t;
    endfunction

    // ---------------- reference model ----------------
    // Frame progress is tracked as a raster index; coordinates come from index arithmetic.
    bit         m_wait = 0;
    bit         m_frame = 0;
    bit         m_done_next = 0;
    bit         m_err = 0;
    int         m_idx = 0;
    int         m_fleft = 0;
    logic       e_ce = 0;
    logic [7:0] e_pix = 0;
    logic [9:0] e_x = 0;
    logic [9:0] e_y = 0;
    logic       e_xyv = 0;
    logic       e_eol = 0;
    logic       e_done = 0;
    int         obs_fce = 0;
    int         obs_done = 0;

    task automatic tick(input logic st, input logic v, input logic s, input logic dr,
                        input logic r, input logic [7:0] d);
        logic rdy;
        logic exp_rdy;
        logic beat;
        logic exp_busy;
        int   p;
        exp_rdy = (m_wait || m_frame) && dr;
        drive(st, v, s, dr, r, d, rdy);
        if (!r) check("pix_rdy", 64'(rdy), 64'(exp_rdy));
        beat   = v && exp_rdy;
        p      = -1;
        e_ce   = 1'b0;
        e_done = 1'b0;
        if (r) begin
            m_wait = 0; m_frame = 0; m_done_next = 0; m_err = 0; m_idx = 0; m_fleft = 0;
            e_pix = 0; e_x = 0; e_y = 0; e_xyv = 0; e_eol = 0;
        end else if (m_wait) begin
            if (beat && s) begin
                m_wait  = 0;
                m_frame = 1;
                p       = 0;
            end
        end else if (m_frame) begin
            if (beat) begin
                if (s) begin
                    if (m_idx != 0) m_err = 1;
                    m_idx = 0;
                end
                p = m_idx;
            end
        end else if (m_fleft > 0) begin
            e_ce  = dr;
            e_pix = 8'd0;
            e_xyv = 1'b0;
            e_eol = 1'b0;
            if (dr) begin
                m_fleft--;
                if (m_fleft == 0) m_done_next = 1;
            end
        end else if (m_done_next) begin
            e_done      = 1'b1;
            m_done_next = 0;
        end else if (st) begin
            m_wait = 1;
        end
        if (p >= 0) begin
            e_ce  = 1'b1;
            e_pix = d;
            e_x   = 10'(p % COLS);
            e_y   = 10'(p / COLS);
            e_xyv = 1'b1;
            e_eol = ((p % COLS) == COLS - 1);
            m_idx = p + 1;
            if (m_idx == NPIX) begin
                m_frame = 0;
                m_fleft = FLEN;
            end
        end
        exp_busy = m_wait || m_frame || (m_fleft > 0) || m_done_next;
        check("outputs", 64'(outs()),
              64'(mk(e_ce, e_pix, e_x, e_y, e_xyv, e_eol, exp_busy, e_done, m_err)));
        if (ce && !xy_coord_vld) obs_fce++;
        if (frame_done) obs_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        obs_fce  = 0;
        obs_done = 0;
    endtask

    task automatic pixels(input int first, input int n, input bit sof_first);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b1, sof_first && (i == 0), 1'b1, 1'b0, 8'(8'h80 + first + i));
    endtask

    task automatic end_counts();
        check("flush_ce_count", 64'(obs_fce), 64'(FLEN));
        check("frame_done_count", 64'(obs_done), 64'd1);
    endtask

    initial begin
        logic rdy;

        // Reset: every output low
        scen = "reset";
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hff);
        do_reset();
        check("all_zero", 64'(outs()), 64'd0);
        idle(2);

        // Nominal frame from a table
        scen = "table";
        tbl[0] = mkvec(1, 0, 0, 1, 8'h00, 0, mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < NPIX; i++)
            tbl[1+i] = mkvec((i == 4), 1, (i == 0), 1, 8'(8'h40 + i), 1,
                             mk(1, 8'(8'h40 + i), 10'(i % COLS), 10'(i / COLS), 1,
                                (i % COLS) == COLS - 1, 1, 0, 0));
        for (int j = 0; j < FLEN; j++)
            tbl[13+j] = mkvec((j == 2), 1, 0, 1, 8'hee, 0, mk(1, 8'h00, 3, 2, 0, 0, 1, 0, 0));
        tbl[23] = mkvec(0, 1, 0, 1, 8'hee, 0, mk(0, 8'h00, 3, 2, 0, 0, 0, 1, 0));
        tbl[24] = mkvec(0, 1, 1, 1, 8'hee, 0, mk(0, 8'h00, 3, 2, 0, 0, 0, 0, 0));
        for (int k = 0; k < 25; k++) begin
            drive(tbl[k].st, tbl[k].v, tbl[k].s, tbl[k].dr, 1'b0, tbl[k].d, rdy);
            check($sformatf("rdy[%0d]", k), 64'(rdy), 64'(tbl[k].e_rdy));
            check($sformatf("out[%0d]", k), 64'(outs()), 64'(tbl[k].e_out));
        end

        // Junk before SOF
        scen = "junk";
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        pixels(0, NPIX, 1);
        idle(13);
        end_counts();

        // Backpressure at (2,1)
        scen = "backpressure";
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        pixels(0, 6, 1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h86);
        check("hold_x", 64'(x_coord), 64'd1);
        check("hold_y", 64'(y_coord), 64'd1);
        pixels(6, 6, 0);
        idle(13);
        end_counts();

        // SOF on the 6th beat
        scen = "mid_sof";
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        pixels(0, 5, 1);
        pixels(0, NPIX, 1);
        check("err_sof", 64'(err_sof), 64'd1);
        idle(13);
        check("err_sticky", 64'(err_sof), 64'd1);
        end_counts();

        // Reset after 4 flush pulses, then a clean frame
        scen = "rst_flush";
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        pixels(0, NPIX, 1);
        idle(4);
        do_reset();
        check("all_zero", 64'(outs()), 64'd0);
        idle(14);
        check("no_done", 64'(obs_done), 64'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        pixels(0, NPIX, 1);
        idle(13);
        end_counts();

        // dn_rdy toggling during flush
        scen = "flush_stall";
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        pixels(0, NPIX, 1);
        for (int i = 0; i < 26; i++) tick(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b0, 8'd0);
        end_counts();

        // Randomized traffic against the model
        scen = "random";
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic st, v, s, dr;
            st = ($urandom % 8) == 0;
            v  = ($urandom % 10) < 7;
            dr = ($urandom % 4) != 0;
            s  = m_wait ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
            tick(st, v, s, dr, 1'b0, 8'($urandom));
        end
        check("random_frames_seen", 64'(obs_done > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
